// File: rtl/bisc_select_seq_gen_pkg.sv
// Shared types and helpers for the BISC bit-select sequence generator.
package bisc_sel_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Widest operand the ctz helper accepts; lanes zero-extend into it.
    localparam int CTZ_MAX_W = 32;

    // Count trailing zeros among the low w bits of v; returns w when none is set.
    function automatic int ctz(input logic [CTZ_MAX_W-1:0] v, input int w);
        int n;
        n = w;
        for (int i = CTZ_MAX_W - 1; i >= 0; i--) begin
            if (i < w && v[i]) begin
                n = i;
            end
        end
        return n;
    endfunction

    // Precision 0 would give a one-entry stream with no selector; keep p in 1..bin_len.
    function automatic int clamp_prec(input int prec, input int bin_len);
        int p;
        p = prec;
        if (p < 1) begin
            p = 1;
        end else if (p > bin_len) begin
            p = bin_len;
        end
        return p;
    endfunction

endpackage

// File: rtl/bisc_select_seq_gen_if.sv
// Control/stream bundle between the sequence generator and its consumer.
interface bisc_select_seq_gen_if #(
    parameter int BIN_LEN = 8,
    parameter int NUM_CH  = 4
);
    localparam int BIN_WIDTH = $clog2(BIN_LEN);
    localparam int PW        = $clog2(BIN_LEN + 1);

    logic                        start;
    logic [PW-1:0]               prec;
    logic                        enable;
    logic                        abort;
    logic                        busy;
    logic [NUM_CH*BIN_WIDTH-1:0] selector;
    logic [NUM_CH-1:0]           zero_select;
    logic                        out_valid;
    logic                        out_last;

    modport master (
        output start, prec, enable, abort,
        input  busy, selector, zero_select, out_valid, out_last
    );

    modport slave (
        input  start, prec, enable, abort,
        output busy, selector, zero_select, out_valid, out_last
    );
endinterface

// File: rtl/bisc_select_seq_gen_lane.sv
// One lane: maps the shared stream position (plus this lane's phase) to a bit select.
module bisc_sel_lane
    import bisc_sel_pkg::*;
#(
    parameter int BIN_LEN     = 8,
    parameter int BIN_WIDTH   = $clog2(BIN_LEN),
    parameter int PW          = $clog2(BIN_LEN + 1),
    parameter int LANE_OFFSET = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [BIN_LEN-1:0]   i_cyc,
    input  logic [PW-1:0]        i_p_q,
    input  logic                 i_load,
    output logic [BIN_WIDTH-1:0] o_selector,
    output logic                 o_zero_select
);
    localparam logic [BIN_LEN-1:0] ONES = '1;

    logic [BIN_LEN-1:0]   w_mask;
    logic [BIN_LEN-1:0]   w_lc;
    logic [BIN_LEN-1:0]   w_lc_inc;
    logic                 w_zero;
    logic [BIN_WIDTH-1:0] w_sel;
    logic [BIN_WIDTH-1:0] r_selector;
    logic                 r_zero_select;

    // Wrap the phased position into the stream length with a mask, then ruler-map it.
    always_comb begin
        w_mask   = ONES >> (PW'(BIN_LEN) - i_p_q);
        w_lc     = (i_cyc + BIN_LEN'(LANE_OFFSET)) & w_mask;
        w_lc_inc = w_lc + BIN_LEN'(1);
        w_zero   = (w_lc == w_mask);
        w_sel    = '0;
        if (!w_zero) begin
            w_sel = BIN_WIDTH'(BIN_LEN - 1 - ctz(CTZ_MAX_W'(w_lc_inc), 32'(i_p_q)));
        end
    end

    // Output registers load only on an advancing cycle and otherwise hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_selector    <= '0;
            r_zero_select <= 1'b0;
        end else if (i_load) begin
            r_selector    <= w_sel;
            r_zero_select <= w_zero;
        end
    end

    assign o_selector    = r_selector;
    assign o_zero_select = r_zero_select;
endmodule

// File: rtl/bisc_select_seq_gen.sv
// Ruler-sequence bit-select generator: run control, stream counter and lane array.
module bisc_select_seq_gen
    import bisc_sel_pkg::*;
#(
    parameter int BIN_LEN     = 8,
    parameter int BIN_WIDTH   = $clog2(BIN_LEN),
    parameter int NUM_CH      = 4,
    parameter int OFFSET_STEP = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    bisc_select_seq_gen_if.slave   bus
);
    localparam int PW = $clog2(BIN_LEN + 1);
    localparam logic [BIN_LEN-1:0] ONES = '1;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [BIN_LEN-1:0]          r_cyc;
    logic [PW-1:0]               r_p_q;
    logic                        r_out_valid;
    logic                        r_out_last;
    logic [BIN_LEN-1:0]          w_mask;
    logic                        w_at_last;
    logic                        w_load;
    logic                        w_accept;
    logic [NUM_CH*BIN_WIDTH-1:0] w_selector;
    logic [NUM_CH-1:0]           w_zero_select;

    assign w_mask    = ONES >> (PW'(BIN_LEN) - r_p_q);
    assign w_at_last = (r_cyc == w_mask);

    // Next state and advance strobe; abort outranks both enable and completion.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.enable) begin
                    w_load = 1'b1;
                    if (w_at_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, stream counter, latched precision and stream framing flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cyc       <= '0;
            r_p_q       <= PW'(1);
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_load;
            r_out_last  <= w_load && w_at_last;
            if (w_accept) begin
                r_cyc <= '0;
                r_p_q <= PW'(clamp_prec(32'(bus.prec), BIN_LEN));
            end else if (w_load) begin
                r_cyc <= r_cyc + BIN_LEN'(1);
            end
        end
    end

    for (genvar l = 0; l < NUM_CH; l++) begin : g_lane
        bisc_sel_lane #(
            .BIN_LEN     (BIN_LEN),
            .BIN_WIDTH   (BIN_WIDTH),
            .PW          (PW),
            .LANE_OFFSET (l * OFFSET_STEP)
        ) u_lane (
            .clock         (clock),
            .reset         (reset),
            .i_cyc         (r_cyc),
            .i_p_q         (r_p_q),
            .i_load        (w_load),
            .o_selector    (w_selector[l*BIN_WIDTH +: BIN_WIDTH]),
            .o_zero_select (w_zero_select[l])
        );
    end

    assign bus.busy        = (r_state == ST_RUN);
    assign bus.selector    = w_selector;
    assign bus.zero_select = w_zero_select;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_last    = r_out_last;
endmodule

// File: tb/tb_bisc_select_seq_gen.sv
// Directed bench for bisc_select_seq_gen (BIN_LEN=8, NUM_CH=4, OFFSET_STEP=1).
module tb_bisc_select_seq_gen;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    int exp_l0[8] = '{7, 6, 7, 5, 7, 6, 7, 0};
    int exp_l1[8] = '{6, 7, 5, 7, 6, 7, 0, 7};
    int stall_pat[4] = '{1, 0, 0, 1};

    always #5 clock = ~clock;

    bisc_select_seq_gen_if #(.BIN_LEN(8), .NUM_CH(4)) bus ();

    bisc_select_seq_gen #(
        .BIN_LEN     (8),
        .NUM_CH      (4),
        .OFFSET_STEP (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lane_sel(input int l);
        return int'(bus.selector[l*3 +: 3]);
    endfunction

    // Independent ruler model: selector for stream position lc at precision p.
    function automatic int model_sel(input int lc, input int p);
        int v;
        int t;
        if (lc == (1 << p) - 1) return 0;
        v = lc + 1;
        t = 0;
        while (v % 2 == 0) begin
            v = v / 2;
            t++;
        end
        return 7 - t;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_run(input int p);
        bus.prec  = 4'(p);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_full(input int p_in, input string tag);
        int cnt[8];
        int nzero0;
        int nzero1;
        int nlast;
        for (int b = 0; b < 8; b++) cnt[b] = 0;
        nzero0 = 0;
        nzero1 = 0;
        nlast  = 0;
        bus.enable = 1'b1;
        start_run(p_in);
        chk({tag, "_busy"}, bus.busy, 1);
        for (int i = 0; i < 256; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || lane_sel(0) != model_sel(i, 8)) begin
                chk({tag, "_seq"}, lane_sel(0), model_sel(i, 8));
            end
            if (bus.zero_select[0]) nzero0++;
            else cnt[lane_sel(0)]++;
            if (bus.zero_select[1]) nzero1++;
            if (bus.out_last) nlast++;
        end
        chk({tag, "_last_end"}, bus.out_last, 1);
        chk({tag, "_nlast"}, nlast, 1);
        chk({tag, "_busy_end"}, bus.busy, 0);
        chk({tag, "_zero0"}, nzero0, 1);
        chk({tag, "_zero1"}, nzero1, 1);
        for (int b = 0; b < 8; b++) chk({tag, "_count"}, cnt[b], 1 << b);
        bus.enable = 1'b0;
        tick();
    endtask

    initial begin
        int idx;
        bus.start  = 1'b0;
        bus.prec   = '0;
        bus.enable = 1'b0;
        bus.abort  = 1'b0;

        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_sel", bus.selector, 0);
        chk("rst_zero", bus.zero_select, 0);
        #21;
        reset = 1'b1;
        tick();

        // prec=3, enable held high: lanes 0 and 1
        bus.enable = 1'b1;
        start_run(3);
        chk("p3_busy", bus.busy, 1);
        chk("p3_valid0", bus.out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("p3_valid", bus.out_valid, 1);
            chk("p3_l0sel", lane_sel(0), exp_l0[i]);
            chk("p3_l0zero", bus.zero_select[0], (i == 7) ? 1 : 0);
            chk("p3_l1sel", lane_sel(1), exp_l1[i]);
            chk("p3_l1zero", bus.zero_select[1], (i == 6) ? 1 : 0);
            chk("p3_last", bus.out_last, (i == 7) ? 1 : 0);
        end
        chk("p3_busy_end", bus.busy, 0);
        tick();
        chk("p3_idle_valid", bus.out_valid, 0);
        chk("p3_idle_last", bus.out_last, 0);
        chk("p3_hold_zero0", bus.zero_select[0], 1);
        chk("p3_hold_l1sel", lane_sel(1), 7);

        // enable pattern 1,0,0,1: same sequence, no skips or repeats
        bus.enable = 1'b0;
        start_run(3);
        idx = 0;
        for (int k = 0; k < 64 && idx < 8; k++) begin
            bus.enable = stall_pat[k % 4][0];
            tick();
            chk("stall_valid", bus.out_valid, stall_pat[k % 4]);
            if (stall_pat[k % 4] == 1) begin
                chk("stall_l0sel", lane_sel(0), exp_l0[idx]);
                chk("stall_l1sel", lane_sel(1), exp_l1[idx]);
                chk("stall_last", bus.out_last, (idx == 7) ? 1 : 0);
                idx++;
            end
        end
        chk("stall_len", idx, 8);
        chk("stall_busy_end", bus.busy, 0);
        bus.enable = 1'b0;
        tick();

        // abort on the 4th enabled cycle
        bus.enable = 1'b1;
        start_run(3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ab_l0sel", lane_sel(0), exp_l0[i]);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab_valid", bus.out_valid, 0);
        chk("ab_last", bus.out_last, 0);
        chk("ab_busy", bus.busy, 0);
        tick();
        chk("ab_after_valid", bus.out_valid, 0);
        chk("ab_after_busy", bus.busy, 0);

        // start mid-run is ignored
        start_run(3);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                bus.start = 1'b1;
                bus.prec  = 4'd1;
            end
            tick();
            bus.start = 1'b0;
            chk("mid_l0sel", lane_sel(0), exp_l0[i]);
            chk("mid_last", bus.out_last, (i == 7) ? 1 : 0);
        end
        chk("mid_busy_end", bus.busy, 0);
        tick();

        // abort together with start on the 4th enabled cycle
        start_run(3);
        for (int i = 0; i < 3; i++) tick();
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abst_valid", bus.out_valid, 0);
        chk("abst_last", bus.out_last, 0);
        chk("abst_busy", bus.busy, 0);
        tick();
        chk("abst_after_busy", bus.busy, 0);
        chk("abst_after_valid", bus.out_valid, 0);

        // prec=0 clamps to length 2
        start_run(0);
        tick();
        chk("p0_sel0", lane_sel(0), 7);
        chk("p0_zero0", bus.zero_select[0], 0);
        chk("p0_last0", bus.out_last, 0);
        tick();
        chk("p0_sel1", lane_sel(0), 0);
        chk("p0_zero1", bus.zero_select[0], 1);
        chk("p0_last1", bus.out_last, 1);
        chk("p0_busy", bus.busy, 0);
        bus.enable = 1'b0;
        tick();

        run_full(8, "p8");
        run_full(9, "p9");

        // reset mid-run clears outputs without waiting for a clock
        bus.enable = 1'b1;
        start_run(3);
        for (int i = 0; i < 3; i++) tick();
        chk("rmid_pre_sel", lane_sel(0), 7);
        #2;
        reset = 1'b0;
        #1;
        chk("rmid_busy", bus.busy, 0);
        chk("rmid_valid", bus.out_valid, 0);
        chk("rmid_last", bus.out_last, 0);
        chk("rmid_sel", bus.selector, 0);
        chk("rmid_zero", bus.zero_select, 0);
        #2;
        reset = 1'b1;
        tick();
        chk("rmid_idle_busy", bus.busy, 0);
        chk("rmid_idle_valid", bus.out_valid, 0);
        bus.enable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bisc_select_seq_gen.md
Name: bisc_select_seq_gen

Overview:
- ROM-free, parametrised bit-select sequence generator for the BISC stochastic MVM datapath.
- For each of NUM_CH lanes it emits, once per enabled cycle, which bit of a BIN_LEN-bit binary operand feeds the bit-serial multiplier, plus a zero-select strobe.
- The sequence is the ruler sequence: bit BIN_LEN-1-k is chosen 2^(prec-1-k) times, and the zero strobe fires once per stream.
- Adds runtime precision, per-lane phase offset, a start/done handshake and abort.

Parameters:
- BIN_LEN, 8: binary operand width; full stream length is 2^BIN_LEN.
- BIN_WIDTH, $clog2(BIN_LEN): selector width; derived, not overridden.
- NUM_CH, 4: number of lanes.
- OFFSET_STEP, 1: phase offset between adjacent lanes, in stream positions.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- prec  in  $clog2(BIN_LEN+1)  stream precision p; latched on start.
- enable  in  1  advance strobe; 0 stalls everything.
- abort  in  1  cancel the run.
- busy  out  1  high in RUN.
- selector  out  NUM_CH*BIN_WIDTH  lane l occupies bits [l*BIN_WIDTH +: BIN_WIDTH].
- zero_select  out  NUM_CH  per-lane zero strobe.
- out_valid  out  1  selector and zero_select are meaningful this cycle.
- out_last  out  1  final stream position; coincides with out_valid.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; cyc=0; p_q=1.
  - All outputs 0: busy, selector, zero_select, out_valid, out_last.
- Precision clamp at start: prec=0 latches as 1; prec>BIN_LEN latches as BIN_LEN.
- Stream length is L=2^p_q.
- States: IDLE and RUN.
  - IDLE to RUN when start=1: p_q latched, cyc cleared to 0.
  - RUN to IDLE on an enabled cycle with cyc==L-1 (normal completion), or on abort=1.
  - start in RUN is ignored.
- Lane position: lc_l = (cyc + l*OFFSET_STEP) mod L. Compute as a mask by L-1; do not divide.
- Lane mapping:
  - If lc_l == L-1: zero_select[l]=1 and selector_l=0.
  - Otherwise: zero_select[l]=0 and selector_l = BIN_LEN-1-ctz(lc_l+1), with ctz over p_q bits.
  - Range is therefore BIN_LEN-p_q .. BIN_LEN-1.
- Outputs are registered, one-cycle latency. On each clock edge in RUN with enable=1:
  - Outputs load the mapping of the current cyc.
  - out_valid<=1.
  - out_last<=(cyc==L-1).
  - cyc increments.
- Any other cycle: out_valid<=0 and out_last<=0; selector and zero_select hold their last value.
- Stall: enable=0 freezes cyc. The stream resumes without skip or repeat.
- Abort:
  - Highest priority: beats enable and completion in the same cycle.
  - Next cycle: out_valid=0, out_last=0, busy=0.
  - No out_last is produced for an aborted stream.
- Start in the cycle after the last: accepted. Back-to-back streams have a one-cycle IDLE gap.
- busy is combinational from state (RUN), with no added latency.
- Each lane fires zero_select exactly once per complete stream.
- Lane 0 with full precision reproduces the legacy BISC select sequence.
- Reset mid-run: immediate return to IDLE with all outputs 0.

Decomposition:
- Package bisc_sel_pkg holds:
  - the state enum (IDLE, RUN);
  - a ctz function, priority-encoder style, parametrised by width;
  - the precision clamp function.
- Sub-module bisc_sel_lane, instantiated NUM_CH times via generate. It takes cyc, p_q, LANE_OFFSET and the load strobe, and owns that lane's selector and zero_select registers.
- The top owns the FSM, cyc, busy, out_valid and out_last.

Test Plan:
- BIN_LEN=8, NUM_CH=1, prec=3, enable held 1.
  -> selector 7,6,7,5,7,6,7,0; zero_select only on the 8th output; out_last on the 8th output; busy drops the cycle after.
- NUM_CH=2, OFFSET_STEP=1, prec=3.
  -> lane1 selector 6,7,5,7,6,7,0,7; lane1 zero_select on the 7th output.
- prec=8, full run (256 outputs).
  -> counts: bit7 x128, bit6 x64, ... bit0 x1; zero_select x1; matches the legacy ruler table.
- prec=3, enable toggled 1,0,0,1,...
  -> identical output sequence, out_valid only on cycles following enable=1; no skipped or repeated positions.
- Abort on the 4th enabled cycle, and also with start asserted mid-run.
  -> out_valid=0 next cycle, no out_last, busy=0; the mid-run start does not restart the stream.
- prec=0 and prec=9 at start; reset pulsed low mid-run.
  -> prec=0 gives length 2: 7,0; prec=9 gives length 256; reset clears all outputs asynchronously and returns to IDLE.
